// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divider controller slice.
//   - divc_state_e : controller FSM encodings (DIVC_FAST exists only with DIV_FAST_EN)
//   - div_state_e  : divider FSM states, kept here so both sides agree on naming
//   - HI/LO field positions within the 64-bit {remainder, quotient} result
// Optional feature macro: DIV_FAST_EN (zero-operand fast path).
package div_pkg;

    typedef enum logic [2:0] {
        DIVC_IDLE  = 3'd0,
        DIVC_BUSY  = 3'd1,
        DIVC_DONE  = 3'd2,
        DIVC_DRAIN = 3'd3
`ifdef DIV_FAST_EN
        ,
        DIVC_FAST  = 3'd4
`endif
    } divc_state_e;

    typedef enum logic [1:0] {
        DivIdle   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } div_state_e;

    // result_o layout: remainder in the upper word, quotient in the lower word
    localparam int unsigned HI_MSB = 63;
    localparam int unsigned HI_LSB = 32;
    localparam int unsigned LO_MSB = 31;
    localparam int unsigned LO_LSB = 0;

    function automatic logic [31:0] hi_field(input logic [63:0] result);
        return result[HI_MSB:HI_LSB];
    endfunction

    function automatic logic [31:0] lo_field(input logic [63:0] result);
        return result[LO_MSB:LO_LSB];
    endfunction

endpackage

// File: rtl/div_fast_chk.sv
// div_fast_chk: zero-operand detector for the divide fast path.
// Present only when DIV_FAST_EN is defined.
//   opdata1  in  32  dividend
//   opdata2  in  32  divisor
//   zero_op  out 1   either operand is zero, so the result is known to be 0
`ifdef DIV_FAST_EN
module div_fast_chk (
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic        zero_op
);

    assign zero_op = (opdata1 == 32'd0) || (opdata2 == 32'd0);

endmodule
`endif

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage initiator for the iterative divider.
// Issues DIV/DIVU to the divider, holds operands/signed flag stable while it runs,
// stalls the pipeline, cancels in-flight divides on flush and returns HI/LO.
// Optional feature macro: DIV_FAST_EN (skip the divider when an operand is zero).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ex_div_valid/ex_div_signed DIV/DIVU instruction in EX, 1 = signed
//   ex_opdata1/ex_opdata2      dividend / divisor
//   ex_hold, flush             downstream stall / cancel of the EX instruction
//   stall_req                  hold IF/ID/EX
//   div_start/div_annul/div_signed/div_opdata1/div_opdata2  registered, to divider
//   div_ready/div_result       from divider, result = {remainder, quotient}
//   hilo_we, hi_o, lo_o        one-cycle HI/LO write; hi/lo are 0 when not writing
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_opdata1,
    input  logic [31:0] ex_opdata2,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stall_req,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    divc_state_e      state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             start_q, start_d;
    logic             annul_q, annul_d;
    logic             signed_q, signed_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic             issue;
    logic             fast_hit;
    logic             stall_raw;
    logic             we_raw;

`ifdef DIV_FAST_EN
    logic zero_op;

    div_fast_chk u_fast_chk (
        .opdata1 (ex_opdata1),
        .opdata2 (ex_opdata2),
        .zero_op (zero_op)
    );

    assign fast_hit = zero_op;
`else
    assign fast_hit = 1'b0;
`endif

    assign issue = ex_div_valid & ~flush;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        start_d     = start_q;
        annul_d     = annul_q;
        signed_d    = signed_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        stall_raw   = 1'b0;
        we_raw      = 1'b0;

        case (state_q)
            DIVC_IDLE: begin
                stall_raw = issue;
                start_d   = 1'b0;
                annul_d   = 1'b0;
                if (issue) begin
                    if (fast_hit) begin
`ifdef DIV_FAST_EN
                        state_d = DIVC_FAST;
`endif
                    end else begin
                        op1_d    = ex_opdata1;
                        op2_d    = ex_opdata2;
                        signed_d = ex_div_signed;
                        start_d  = 1'b1;
                        state_d  = DIVC_BUSY;
                    end
                end
            end

            DIVC_BUSY: begin
                stall_raw = 1'b1;
                // Flush wins over completion, even with div_ready high.
                if (flush) begin
                    stall_raw   = 1'b0;
                    start_d     = 1'b0;
                    annul_d     = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = DIVC_DRAIN;
                end else if (div_ready && !ex_hold) begin
                    stall_raw = 1'b0;
                    we_raw    = 1'b1;
                    start_d   = 1'b0;
                    state_d   = DIVC_DONE;
                end
                // div_ready with ex_hold: start stays high so the divider parks in DivEnd.
            end

            DIVC_DONE: begin
                // Dropping start here returns the divider to DivIdle; a following
                // divide waits this one cycle.
                stall_raw = ex_div_valid;
                state_d   = DIVC_IDLE;
            end

            DIVC_DRAIN: begin
                stall_raw   = ex_div_valid;
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    annul_d     = 1'b0;
                    drain_cnt_d = '0;
                    state_d     = DIVC_IDLE;
                end
            end

`ifdef DIV_FAST_EN
            DIVC_FAST: begin
                we_raw  = ~flush;
                state_d = DIVC_IDLE;
            end
`endif

            default: begin
                state_d = DIVC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DIVC_IDLE;
            drain_cnt_q <= '0;
            start_q     <= 1'b0;
            annul_q     <= 1'b0;
            signed_q    <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            start_q     <= start_d;
            annul_q     <= annul_d;
            signed_q    <= signed_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
        end
    end

    assign stall_req   = stall_raw & ~reset;
    assign hilo_we     = we_raw & ~reset;
    assign div_start   = start_q;
    assign div_annul   = annul_q;
    assign div_signed  = signed_q;
    assign div_opdata1 = op1_q;
    assign div_opdata2 = op2_q;

    // In the fast path hilo_we is set outside BUSY, where div_result is stale;
    // the zero-result case is selected explicitly.
    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        if (hilo_we && (state_q == DIVC_BUSY)) begin
            hi_o = hi_field(div_result);
            lo_o = lo_field(div_result);
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural divider model,
// a scoreboard queue of expected {hi, lo} and an independent monitor.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_div_valid;
    logic        ex_div_signed;
    logic [31:0] ex_opdata1;
    logic [31:0] ex_opdata2;
    logic        ex_hold;
    logic        flush;
    logic        stall_req;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_ready;
    logic [63:0] div_result;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;
    int unsigned lat = 4;
    int unsigned dcnt;
    logic [63:0] exp_q[$];
    logic        start_seen = 1'b0;
    logic [64:0] held_ops;

    always #5 clk = ~clk;

    div_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_div_valid  (ex_div_valid),
        .ex_div_signed (ex_div_signed),
        .ex_opdata1    (ex_opdata1),
        .ex_opdata2    (ex_opdata2),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .stall_req     (stall_req),
        .div_start     (div_start),
        .div_annul     (div_annul),
        .div_signed    (div_signed),
        .div_opdata1   (div_opdata1),
        .div_opdata2   (div_opdata2),
        .div_ready     (div_ready),
        .div_result    (div_result),
        .hilo_we       (hilo_we),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    // Reference: truncating division in 64-bit arithmetic, {remainder, quotient};
    // divide-by-zero yields 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider model: counts while started and not annulled, then holds the result
    // until start drops. Result is junk when not ready.
    always @(posedge clk) begin
        if (reset || !div_start || div_annul) begin
            dcnt       <= 0;
            div_ready  <= 1'b0;
            div_result <= {$urandom, $urandom};
        end else if (!div_ready) begin
            if (dcnt >= lat) begin
                div_ready  <= 1'b1;
                div_result <= ref_div(div_opdata1, div_opdata2, div_signed);
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every HI/LO write and watches operand stability.
    always @(negedge clk) begin
        if (hilo_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hilo_we: got hi=%0h lo=%0h, expected no write (t=%0t)",
                         hi_o, lo_o, $time);
            end else begin
                check("hilo_result", {hi_o, lo_o}, exp_q.pop_front());
            end
        end else begin
            check("hilo_zero_when_idle", {hi_o, lo_o}, 96'd0);
        end
        if (div_start && start_seen) begin
            check("ops_held_while_busy", {div_signed, div_opdata1, div_opdata2}, held_ops);
        end else if (div_start) begin
            held_ops = {div_signed, div_opdata1, div_opdata2};
        end
        start_seen = div_start;
    end

    // Presents a divide and waits for its HI/LO write; valid is left high.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [63:0] exp);
        bit done = 0;
        exp_q.push_back(exp);
        ex_div_valid  = 1'b1;
        ex_div_signed = sgn;
        ex_opdata1    = a;
        ex_opdata2    = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (hilo_we) begin
                done = 1;
                check("stall_low_at_completion", 96'(stall_req), 96'd0);
            end else begin
                check("stall_high_in_flight", 96'(stall_req), 96'd1);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL divide_timeout: got no hilo_we, expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop_valid();
        ex_div_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!div_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!div_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: got div_ready=0, expected 1 within 200 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int annul_cnt;
        logic [31:0] a, b;
        logic sgn;

        reset = 1'b1;
        ex_div_valid = 1'b0;
        ex_div_signed = 1'b0;
        ex_opdata1 = 32'd0;
        ex_opdata2 = 32'd0;
        ex_hold = 1'b0;
        flush = 1'b0;
        ex_div_valid = 1'b1;  // stall must stay low while in reset
        ex_opdata1 = 32'd3;
        ex_opdata2 = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 96'(stall_req), 96'd0);
        check("reset_regs", {div_start, div_annul, div_signed, div_opdata1, div_opdata2}, 96'd0);
        check("reset_hilo", {hilo_we, hi_o, lo_o}, 96'd0);
        ex_div_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases with hand-derived results
        lat = 5;
        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        drop_valid();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        drop_valid();
        run_div(32'd5, 32'd0, 1'b0, 64'd0);
        drop_valid();
        run_div(32'd8, 32'd2, 1'b0, {32'd0, 32'd4});
        run_div(32'd9, 32'd4, 1'b0, {32'd1, 32'd2});
        drop_valid();

        // Hold while the result is ready: start stays up, no write until released
        lat = 4;
        ex_hold = 1'b1;
        exp_q.push_back({32'd2, 32'd8});
        ex_div_valid = 1'b1;
        ex_div_signed = 1'b0;
        ex_opdata1 = 32'd50;
        ex_opdata2 = 32'd6;
        wait_ready("hold_wait_ready");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_start_high", 96'(div_start), 96'd1);
            check("hold_no_write", 96'(hilo_we), 96'd0);
        end
        @(posedge clk);
        #1 ex_hold = 1'b0;
        @(negedge clk);
        check("hold_release_write", 96'(hilo_we), 96'd1);
        @(posedge clk);
        #1;
        drop_valid();

        // Flush 10 cycles after issue: no write, annul for two cycles
        lat = 20;
        ex_div_valid = 1'b1;
        ex_opdata1 = 32'd77;
        ex_opdata2 = 32'd5;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        ex_div_valid = 1'b0;
        annul_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (div_annul) annul_cnt++;
            check("drain_start_low", 96'(div_start), 96'd0);
        end
        check("drain_annul_cycles", 96'(annul_cnt), 96'd2);
        @(posedge clk);
        #1 lat = 3;
        run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});
        drop_valid();

        // Flush in the same cycle as a ready, unheld result: flush wins
        ex_hold = 1'b1;
        ex_div_valid = 1'b1;
        ex_opdata1 = 32'd40;
        ex_opdata2 = 32'd3;
        wait_ready("flush_ready_wait");
        @(posedge clk);
        #1 flush = 1'b1;
        ex_hold = 1'b0;
        @(negedge clk);
        check("flush_beats_completion", 96'(hilo_we), 96'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        ex_div_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Flush in IDLE suppresses issue
        ex_div_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("idle_flush_no_stall", 96'(stall_req), 96'd0);
        @(posedge clk);
        #1 ex_div_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle_flush_no_start", 96'(div_start), 96'd0);
        @(posedge clk);
        #1;

        // Reset mid-divide
        lat = 20;
        ex_div_valid = 1'b1;
        ex_div_signed = 1'b1;
        ex_opdata1 = 32'd1234;
        ex_opdata2 = 32'd17;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        ex_div_valid = 1'b0;
        @(negedge clk);
        check("reset_mid_stall", 96'(stall_req), 96'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_regs", {div_start, div_annul, div_signed, div_opdata1, div_opdata2},
              96'd0);
        @(posedge clk);
        #1;

        // Randomized divides, sometimes back-to-back
        for (int n = 0; n < 25; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            sgn = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 8);
            run_div(a, b, sgn, ref_div(a, b, sgn));
            if ($urandom_range(0, 1) == 0) drop_valid();
        end
        drop_valid();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 96'(exp_q.size()), 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
